// File: rtl/game_board_pkg.sv
// game_board_pkg: shared cell encoding, clear-FSM states and board addressing helper
package game_board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int unsigned rc_addr(input int unsigned row, input int unsigned col,
                                            input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/game_board_memory_if.sv
// game_board_memory_if: write/read/status bundle between game logic, renderer and the board store
interface game_board_memory_if #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int CELL_W = 2
);
    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int CNT_W  = $clog2(CELLS + 1);

    logic              clear;
    logic              we;
    logic              overwrite;
    logic [ADDR_W-1:0] w_addr;
    logic [CELL_W-1:0] data_in;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [CELL_W-1:0] data_out_a;
    logic [CELL_W-1:0] data_out_b;
    logic              wr_ok;
    logic              wr_rej;
    logic              busy;
    logic [CNT_W-1:0]  occ_count;
    logic              full;
    logic              empty;

    modport master (
        output clear, we, overwrite, w_addr, data_in, r_addr_a, r_addr_b,
        input  data_out_a, data_out_b, wr_ok, wr_rej, busy, occ_count, full, empty
    );

    modport slave (
        input  clear, we, overwrite, w_addr, data_in, r_addr_a, r_addr_b,
        output data_out_a, data_out_b, wr_ok, wr_rej, busy, occ_count, full, empty
    );

endinterface

// File: rtl/game_board_clear_fsm.sv
// game_board_clear_fsm: sequences a one-cell-per-cycle sweep clear of the board
module game_board_clear_fsm
    import game_board_pkg::*;
#(
    parameter int CELLS  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    state_t state;

    // Start on clear from IDLE, visit every cell exactly once, ignore clear while sweeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_addr <= '0;
        end else if (state == IDLE) begin
            if (clear) begin
                state    <= CLEAR;
                busy     <= 1'b1;
                clr_addr <= '0;
            end
        end else begin
            if (clr_addr == LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

    assign clr_en = busy;

endmodule

// File: rtl/game_board_memory.sv
// game_board_memory: ROWS x COLS board store with two read ports, guarded writes, sweep clear and occupancy count
module game_board_memory
    import game_board_pkg::*;
#(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int CELL_W = 2
) (
    input logic                 clk,
    input logic                 rst,
    game_board_memory_if.slave  bus
);
    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam logic [ADDR_W:0]  LIM    = (ADDR_W + 1)'(CELLS);
    localparam logic [CNT_W-1:0] FULL_V = CNT_W'(CELLS);

    logic [CELL_W-1:0] cells [CELLS];
    logic [CNT_W-1:0]  occ;
    logic              busy;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              w_in;
    logic              r_in_a;
    logic              r_in_b;
    logic              commit;
    logic [CELL_W-1:0] cur;
    logic [CELL_W-1:0] old_clr;

    game_board_clear_fsm #(
        .CELLS  (CELLS),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.clear),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign w_in    = {1'b0, bus.w_addr} < LIM;
    assign r_in_a  = {1'b0, bus.r_addr_a} < LIM;
    assign r_in_b  = {1'b0, bus.r_addr_b} < LIM;
    assign cur     = w_in ? cells[bus.w_addr] : '0;
    assign old_clr = cells[clr_addr];
    // A clear request in the same cycle wins over the write
    assign commit  = bus.we && !busy && !bus.clear && w_in && (bus.overwrite || cur == '0);

    assign bus.busy      = busy;
    assign bus.occ_count = occ;
    assign bus.full      = occ == FULL_V;
    assign bus.empty     = occ == '0;

    // Cell array, occupancy count and write response; sweep and writes never overlap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= '0;
            occ        <= '0;
            bus.wr_ok  <= 1'b0;
            bus.wr_rej <= 1'b0;
        end else begin
            bus.wr_ok  <= commit;
            bus.wr_rej <= bus.we && !commit;
            if (clr_en) begin
                cells[clr_addr] <= '0;
                if (old_clr != '0) occ <= occ - CNT_W'(1);
            end else if (commit) begin
                cells[bus.w_addr] <= bus.data_in;
                occ <= (cur == '0 && bus.data_in != '0) ? occ + CNT_W'(1) :
                       (cur != '0 && bus.data_in == '0) ? occ - CNT_W'(1) : occ;
            end
        end
    end

    // Registered read ports; out-of-range addresses read as EMPTY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.data_out_a <= '0;
            bus.data_out_b <= '0;
        end else begin
            bus.data_out_a <= r_in_a ? cells[bus.r_addr_a] : '0;
            bus.data_out_b <= r_in_b ? cells[bus.r_addr_b] : '0;
        end
    end

endmodule

// File: doc/game_board_memory.md
# game_board_memory

Parametrised board-state store for the VGA game datapath, generalising the fixed 9-cell, 2-bit board memory to any ROWS×COLS grid and any cell width. It provides:
- two independent registered read ports: port A for the VGA renderer, port B for game logic;
- one write port with optional occupied-cell protection;
- a multi-cycle sweep clear that does not need a reset;
- a live occupied-cell count with full/empty flags.

## Interface
Parameters:
- ROWS, 3, board rows
- COLS, 3, board columns
- CELL_W, 2, bits per cell; value 0 is EMPTY
- CELLS, ROWS*COLS, derived, not overridable
- ADDR_W, $clog2(CELLS), derived
- CNT_W, $clog2(CELLS+1), derived

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  one-cycle request to start a sweep clear
- we  in  1  write enable
- overwrite  in  1  when 0, writes to non-EMPTY cells are rejected
- w_addr  in  ADDR_W  write address, row-major (row*COLS+col)
- data_in  in  CELL_W  write data
- r_addr_a, r_addr_b  in  ADDR_W  read addresses
- data_out_a, data_out_b  out  CELL_W  registered read data
- wr_ok  out  1  one-cycle pulse: write committed
- wr_rej  out  1  one-cycle pulse: write refused
- busy  out  1  sweep clear in progress
- occ_count  out  CNT_W  number of non-EMPTY cells
- full  out  1  occ_count == CELLS
- empty  out  1  occ_count == 0

## Operation
- Storage is a flop array of CELLS × CELL_W, so reset can clear it.
- Reset (rst low, asynchronous) forces:
  - all cells, data_out_a/b, wr_ok, wr_rej, busy, occ_count to 0;
  - empty to 1 and full to 0;
  - the clear FSM to IDLE.
- Reads: for each port, data_out_x <= cell[r_addr_x] every cycle.
  - An out-of-range address (≥ CELLS) returns 0.
  - Reads are read-before-write: a same-cycle write to the same address is not visible until the next read.
- A write evaluated in IDLE is rejected if any of these hold:
  - w_addr ≥ CELLS;
  - overwrite = 0 and the cell is non-EMPTY;
  - clear is asserted in the same cycle (clear has priority).
- Otherwise the write commits.
- Every we cycle produces exactly one of wr_ok or wr_rej, registered, on the next cycle.
- Writing a cell with its current value commits (wr_ok) but leaves occ_count unchanged.
- occ_count update on a committed write:
  - EMPTY → non-EMPTY: +1;
  - non-EMPTY → EMPTY: −1;
  - otherwise unchanged.
- Clear FSM:
  - IDLE → CLEAR on clear, with sweep pointer = 0.
  - CLEAR zeroes cell[ptr] and decrements occ_count if that cell was non-EMPTY, then ptr++.
  - CLEAR → IDLE after ptr = CELLS−1 has been cleared.
  - busy = 1 throughout CLEAR.
  - Any we in CLEAR → wr_rej.
  - clear asserted while in CLEAR is ignored; the sweep does not restart.
- Reads stay live during CLEAR and may show a partially cleared board.
- full and empty are derived combinationally from registered occ_count.

## Timing
- Read latency: 1 cycle from address to data_out.
- Write: the cell updates on the edge where we is sampled. wr_ok/wr_rej and the new occ_count are visible after that edge.
- Clear: busy rises the cycle after clear is sampled and stays high for exactly CELLS cycles. The first write accepted is the one sampled in the cycle busy is low again.
- Reset mid-sweep: everything returns to reset values immediately. The sweep is abandoned.

## Structure
- Package game_board_pkg:
  - cell_t encoding: EMPTY=0, P1=1, P2=2, remaining codes reserved;
  - state enum {IDLE, CLEAR};
  - helper function for the row-major address.
- Sub-module game_board_clear_fsm owns the state, sweep pointer and busy. It exposes clr_en and clr_addr to the array.
- The top level holds the array, read registers, write arbitration and counter.

## Test plan
- Reset, then with defaults write P2 to 0, P1 to 1, P2 to 8 (overwrite=0) → three wr_ok pulses, occ_count=3. Reading port A addr 8 and port B addr 1 in the same cycle → 2 and 1 one cycle later.
- Write P1 to addr 0 with overwrite=0 → wr_rej, cell stays P2. Repeat with overwrite=1 → wr_ok, cell reads 1, occ_count unchanged. Write EMPTY to addr 0 with overwrite=1 → occ_count −1.
- Write to addr 9 and addr 15 → wr_rej, no cell or count change. Reading addr 12 → 0.
- Fill all 9 cells → full=1, occ_count=9. Then:
  - pulse clear → busy high for exactly 9 cycles;
  - a write issued mid-sweep → wr_rej;
  - at the end empty=1 and all reads return 0.
- Assert clear and we in the same cycle → wr_rej and the sweep starts. Pull rst low at sweep cycle 4 → busy=0, count=0 immediately. A write after rst high → wr_ok.
- Parameter run with ROWS=4, COLS=4, CELL_W=3 → write 7 to addr 15, read back 7. full after 16 distinct writes, CNT_W=5.
